mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master memory bus controller that sits between the CPU's instruction-fetch and data ports and the shared memory bus, in front of the BRAM, SRAM, flash and peripheral regions. It arbitrates round-robin between the two masters and decodes the granted address into one-hot region selects using the fixed 64 KiB region map. It sequences each access with a per-region wait-state count and returns read data, an acknowledge, or an error to the granted master.

## Interface
- BRAM_WS, 0: wait states for region 0x0000_xxxx
- SRAM_WS, 1: wait states for region 0x0001_xxxx
- FLASH_WS, 3: wait states for region 0x0002_xxxx
- PERIPH_WS, 1: wait states for region 0x0003_xxxx (all WS values 0..15)

- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction-fetch request (read-only master)
- i_addr  in  32  fetch address
- i_ack  out  1  one-cycle completion pulse to the fetch master
- i_err  out  1  valid with i_ack; 1 = unmapped address
- i_rdata  out  32  fetch data, valid with i_ack
- d_req  in  1  data-master request
- d_addr  in  32  data address
- d_we  in  1  1 = write, 0 = read
- d_be  in  4  byte enables
- d_wdata  in  32  write data
- d_ack  out  1  one-cycle completion pulse to the data master
- d_err  out  1  valid with d_ack; 1 = unmapped address
- d_rdata  out  32  read data, valid with d_ack (0 on writes)
- mem_addr  out  32  latched access address
- mem_we  out  1  write strobe, qualified by a select
- mem_be  out  4  byte enables (4'hF for fetches)
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data from the selected region
- bram_sel, sram_sel, flash_sel, periph_sel  out  1 each  one-hot region selects
- busy  out  1  1 whenever the state is not IDLE

## Operation
- Region decode uses addr[31:16]:
  - 0x0000 → BRAM
  - 0x0001 → SRAM
  - 0x0002 → flash
  - 0x0003 → peripheral
  - any other value → error
- States are IDLE, ACCESS and DONE.
- IDLE:
  - If no request is present, stay in IDLE.
  - If exactly one request is present, grant that master.
  - If both are present, grant the master that was not granted last. The last-granted register resets to "data", so the first tie goes to fetch.
  - On grant, latch grant, address, we, be and wdata. A fetch latches we=0 and be=4'hF.
  - Decoded region → ACCESS, with wait counter loaded from that region's WS.
  - Error region → DONE with the error flag set; no select is asserted.
- ACCESS:
  - Exactly one select is asserted, together with the latched mem_addr, mem_we, mem_be and mem_wdata.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, register mem_rdata and go to DONE.
  - The memory performs the write in the final ACCESS cycle; mem_we stays held for the whole ACCESS.
- DONE:
  - Pulse ack for one cycle to the granted master, with rdata (0 for writes and errors) and err.
  - Update the last-granted register, then go to IDLE.
  - Requests are not sampled in DONE.
- Masters hold req and payload stable until ack. They may deassert req, or present a new request, from the cycle after ack.
- The non-granted master's ack, err and rdata outputs stay 0.

## Timing
- Reset (async, any state, including mid-ACCESS):
  - state = IDLE and last-granted = data.
  - All outputs = 0: acks, errs, rdata, mem_addr, mem_we, mem_be, mem_wdata, selects and busy.
  - An interrupted access is dropped; no ack is issued.
- Request sampled in IDLE at cycle N:
  - Selects are high for cycles N+1 .. N+1+WS.
  - ack is high in cycle N+WS+2.
  - IDLE is re-entered in cycle N+WS+3.
  - Latency is WS+2 cycles; back-to-back throughput is one access per WS+3 cycles.
- Error request sampled at cycle N: ack and err are high in cycle N+1; IDLE in cycle N+2.
- Simultaneous requests at every IDLE strictly alternate grants.
- A request arriving during ACCESS or DONE waits for IDLE.
- Selects are never asserted in IDLE or DONE, and never more than one at a time.

## Test plan
- Reset and BRAM read:
  - Apply reset with rst_n=0 mid-flash access → all outputs 0 immediately (asynchronous).
  - After release, d_req read at 0x0000_0010 with mem_rdata=0xDEADBEEF → bram_sel high 1 cycle, d_ack 2 cycles after the request with d_rdata=0xDEADBEEF, d_err=0.
- Wait states: i_req at 0x0002_0100 (flash, WS=3) → flash_sel high 4 cycles, i_ack at cycle N+5.
- SRAM write: d_req at 0x0001_0004, d_we=1, be=4'b0011, wdata=0x1234_5678 → sram_sel and mem_we high 2 cycles with the latched values, d_ack at N+3, d_rdata=0.
- Error: d_req at 0x0004_0000 → no select asserted, d_ack=1 and d_err=1 at N+1, busy low at N+2.
- Round-robin: i_req and d_req both held continuously, addresses in BRAM → grants I, D, I, D with acks every 3 cycles.
- Reset mid-operation: assert rst_n=0 during a flash ACCESS → no ack issued; after release, a new d_req completes normally and an I/D tie grants I.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two CPU masters, the arbiter and the memory regions.
// The slave view is the arbiter's; the master view is for whatever drives the CPU side.
interface mem_bus_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic        i_err;
  logic [31:0] i_rdata;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic        d_err;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        bram_sel;
  logic        sram_sel;
  logic        flash_sel;
  logic        periph_sel;
  logic        busy;

  modport slave (
    input  i_req, i_addr, d_req, d_addr, d_we, d_be, d_wdata, mem_rdata,
    output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           mem_addr, mem_we, mem_be, mem_wdata,
           bram_sel, sram_sel, flash_sel, periph_sel, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_addr, d_we, d_be, d_wdata, mem_rdata,
    input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
           mem_addr, mem_we, mem_be, mem_wdata,
           bram_sel, sram_sel, flash_sel, periph_sel, busy
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter between fetch and data masters with 64 KiB region decode
// and per-region wait states; one access in flight at a time.
module mem_bus_arbiter #(
  parameter logic [3:0] BRAM_WS   = 4'd0,
  parameter logic [3:0] SRAM_WS   = 4'd1,
  parameter logic [3:0] FLASH_WS  = 4'd3,
  parameter logic [3:0] PERIPH_WS = 4'd1
) (
  input logic               clk,
  input logic               rst_n,
  mem_bus_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic        grant_d;
  logic        last_d;
  logic [3:0]  wait_cnt;

  logic        any_req;
  logic        pick_d;
  logic [31:0] pick_addr;
  logic [3:0]  dec_sel;
  logic [3:0]  dec_ws;

  // On a tie the master that was not served last wins.
  always_comb begin
    any_req   = bus.i_req | bus.d_req;
    pick_d    = bus.d_req & (~bus.i_req | ~last_d);
    pick_addr = pick_d ? bus.d_addr : bus.i_addr;
    dec_sel   = 4'b0000;
    dec_ws    = 4'd0;
    case (pick_addr[31:16])
      16'h0000: begin dec_sel = 4'b0001; dec_ws = BRAM_WS;   end
      16'h0001: begin dec_sel = 4'b0010; dec_ws = SRAM_WS;   end
      16'h0002: begin dec_sel = 4'b0100; dec_ws = FLASH_WS;  end
      16'h0003: begin dec_sel = 4'b1000; dec_ws = PERIPH_WS; end
      default:  begin dec_sel = 4'b0000; dec_ws = 4'd0;      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant_d       <= 1'b0;
      last_d        <= 1'b1;
      wait_cnt      <= 4'd0;
      bus.i_ack     <= 1'b0;
      bus.i_err     <= 1'b0;
      bus.i_rdata   <= 32'd0;
      bus.d_ack     <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.d_rdata   <= 32'd0;
      bus.mem_addr  <= 32'd0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'd0;
      bus.mem_wdata <= 32'd0;
      bus.bram_sel  <= 1'b0;
      bus.sram_sel  <= 1'b0;
      bus.flash_sel <= 1'b0;
      bus.periph_sel <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_d       <= pick_d;
            bus.mem_addr  <= pick_addr;
            bus.mem_be    <= pick_d ? bus.d_be : 4'hF;
            bus.mem_wdata <= pick_d ? bus.d_wdata : 32'd0;
            bus.busy      <= 1'b1;
            if (dec_sel != 4'b0000) begin
              {bus.periph_sel, bus.flash_sel, bus.sram_sel, bus.bram_sel} <= dec_sel;
              bus.mem_we <= pick_d & bus.d_we;
              wait_cnt   <= dec_ws;
              state      <= ACCESS;
            end else begin
              // Unmapped: skip the bus entirely and report the error next cycle.
              if (pick_d) begin
                bus.d_ack <= 1'b1;
                bus.d_err <= 1'b1;
              end else begin
                bus.i_ack <= 1'b1;
                bus.i_err <= 1'b1;
              end
              state <= DONE;
            end
          end
        end

        ACCESS: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            {bus.periph_sel, bus.flash_sel, bus.sram_sel, bus.bram_sel} <= 4'b0000;
            bus.mem_we <= 1'b0;
            if (grant_d) begin
              bus.d_ack   <= 1'b1;
              bus.d_rdata <= bus.mem_we ? 32'd0 : bus.mem_rdata;
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= bus.mem_rdata;
            end
            state <= DONE;
          end
        end

        DONE: begin
          bus.i_ack   <= 1'b0;
          bus.i_err   <= 1'b0;
          bus.i_rdata <= 32'd0;
          bus.d_ack   <= 1'b0;
          bus.d_err   <= 1'b0;
          bus.d_rdata <= 32'd0;
          bus.busy    <= 1'b0;
          last_d      <= grant_d;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reset, region accesses, wait states,
// errors, round-robin alternation and reset during an access.
module tb_mem_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [142:0] all_outs();
    return {bus.i_ack, bus.i_err, bus.d_ack, bus.d_err, bus.bram_sel, bus.sram_sel,
            bus.flash_sel, bus.periph_sel, bus.mem_we, bus.busy, bus.mem_be,
            bus.i_rdata, bus.d_rdata, bus.mem_addr, bus.mem_wdata, 1'b0};
  endfunction

  function automatic logic [3:0] sels();
    return {bus.periph_sel, bus.flash_sel, bus.sram_sel, bus.bram_sel};
  endfunction

  task automatic test_reset();
    #3;
    n_checks++;
    if (all_outs() !== 143'd0) begin
      n_fails++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", all_outs());
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0002_0040;
    tick();
    tick();
    n_checks++;
    if ({sels(), bus.busy} !== 5'b0100_1) begin
      n_fails++;
      $display("[TB] FAIL flash_in_access: got %b expected 01001", {sels(), bus.busy});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 143'd0) begin
      n_fails++;
      $display("[TB] FAIL async_reset_outputs: got %h expected 0", all_outs());
    end
    bus.i_req = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if ({bus.i_ack, bus.d_ack, bus.busy} !== 3'b000) begin
        n_fails++;
        $display("[TB] FAIL no_ack_after_reset: got %b expected 000", {bus.i_ack, bus.d_ack, bus.busy});
      end
    end
  endtask

  task automatic test_bram_read();
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h0000_0010;
    bus.d_we      = 1'b0;
    bus.d_be      = 4'hF;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if ({sels(), bus.mem_addr, bus.d_ack} !== {4'b0001, 32'h0000_0010, 1'b0}) begin
      n_fails++;
      $display("[TB] FAIL bram_access: got sel=%b addr=%h ack=%b expected sel=0001 addr=00000010 ack=0",
               sels(), bus.mem_addr, bus.d_ack);
    end
    tick();
    n_checks++;
    if ({sels(), bus.d_ack, bus.d_err, bus.i_ack, bus.d_rdata} !== {4'b0000, 3'b100, 32'hDEAD_BEEF}) begin
      n_fails++;
      $display("[TB] FAIL bram_ack: got sel=%b ack=%b err=%b iack=%b rdata=%h expected 0000 1 0 0 deadbeef",
               sels(), bus.d_ack, bus.d_err, bus.i_ack, bus.d_rdata);
    end
    tick();
    bus.d_req = 1'b0;
    n_checks++;
    if ({bus.d_ack, bus.busy, bus.d_rdata} !== 34'd0) begin
      n_fails++;
      $display("[TB] FAIL bram_idle: got ack=%b busy=%b rdata=%h expected 0 0 0", bus.d_ack, bus.busy, bus.d_rdata);
    end
  endtask

  task automatic test_wait_states();
    int sel_cycles = 0;
    int ack_at = -1;
    logic [4:0] first_access = 5'd0;
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0002_0100;
    bus.mem_rdata = 32'hCAFE_F00D;
    for (int c = 1; c <= 10 && ack_at < 0; c++) begin
      tick();
      if (bus.flash_sel) sel_cycles++;
      if (c == 1) first_access = {bus.mem_be, bus.mem_we};
      if (bus.i_ack) ack_at = c;
    end
    n_checks++;
    if (sel_cycles !== 4) begin
      n_fails++;
      $display("[TB] FAIL flash_sel_cycles: got %0d expected 4", sel_cycles);
    end
    n_checks++;
    if (ack_at !== 5) begin
      n_fails++;
      $display("[TB] FAIL flash_ack_cycle: got %0d expected 5", ack_at);
    end
    n_checks++;
    if ({bus.i_rdata, bus.i_err, bus.d_ack, first_access} !== {32'hCAFE_F00D, 2'b00, 5'b1111_0}) begin
      n_fails++;
      $display("[TB] FAIL flash_data: got rdata=%h err=%b dack=%b be_we=%b expected cafef00d 0 0 11110",
               bus.i_rdata, bus.i_err, bus.d_ack, first_access);
    end
    tick();
    bus.i_req = 1'b0;
  endtask

  task automatic test_sram_write();
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h0001_0004;
    bus.d_we      = 1'b1;
    bus.d_be      = 4'b0011;
    bus.d_wdata   = 32'h1234_5678;
    bus.mem_rdata = 32'h5555_AAAA;
    for (int c = 1; c <= 2; c++) begin
      tick();
      n_checks++;
      if ({sels(), bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.d_ack} !==
          {4'b0010, 1'b1, 32'h0001_0004, 4'b0011, 32'h1234_5678, 1'b0}) begin
        n_fails++;
        $display("[TB] FAIL sram_write_c%0d: got sel=%b we=%b addr=%h be=%b wdata=%h ack=%b expected 0010 1 00010004 0011 12345678 0",
                 c, sels(), bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, bus.d_ack);
      end
    end
    tick();
    n_checks++;
    if ({sels(), bus.mem_we, bus.d_ack, bus.d_err, bus.d_rdata} !== {4'b0000, 3'b010, 32'd0}) begin
      n_fails++;
      $display("[TB] FAIL sram_write_ack: got sel=%b we=%b ack=%b err=%b rdata=%h expected 0000 0 1 0 0",
               sels(), bus.mem_we, bus.d_ack, bus.d_err, bus.d_rdata);
    end
    tick();
    bus.d_req = 1'b0;
    bus.d_we  = 1'b0;
  endtask

  task automatic test_error();
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0004_0000;
    tick();
    n_checks++;
    if ({sels(), bus.d_ack, bus.d_err, bus.busy, bus.d_rdata} !== {4'b0000, 3'b111, 32'd0}) begin
      n_fails++;
      $display("[TB] FAIL error_ack: got sel=%b ack=%b err=%b busy=%b rdata=%h expected 0000 1 1 1 0",
               sels(), bus.d_ack, bus.d_err, bus.busy, bus.d_rdata);
    end
    tick();
    bus.d_req = 1'b0;
    n_checks++;
    if ({bus.busy, bus.d_ack, bus.d_err} !== 3'b000) begin
      n_fails++;
      $display("[TB] FAIL error_idle: got busy=%b ack=%b err=%b expected 000", bus.busy, bus.d_ack, bus.d_err);
    end
  endtask

  task automatic test_round_robin();
    int exp_cycle[4] = '{2, 5, 8, 11};
    logic exp_d[4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    int n_acks = 0;
    bus.i_req     = 1'b1;
    bus.i_addr    = 32'h0000_0100;
    bus.d_req     = 1'b1;
    bus.d_addr    = 32'h0000_0200;
    bus.d_we      = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (bus.i_ack || bus.d_ack) begin
        n_checks++;
        if (n_acks >= 4 || {bus.i_ack, bus.d_ack} !== {~exp_d[n_acks], exp_d[n_acks]} || c != exp_cycle[n_acks]) begin
          n_fails++;
          $display("[TB] FAIL rr_grant%0d: got cycle=%0d iack=%b dack=%b expected cycle=%0d dack=%b",
                   n_acks, c, bus.i_ack, bus.d_ack, (n_acks < 4) ? exp_cycle[n_acks] : -1,
                   (n_acks < 4) ? exp_d[n_acks] : 1'b0);
        end
        n_acks++;
      end
    end
    n_checks++;
    if (n_acks !== 4) begin
      n_fails++;
      $display("[TB] FAIL rr_ack_count: got %0d expected 4", n_acks);
    end
    tick();
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0002_0000;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sels(), bus.busy, bus.mem_addr} !== 37'd0) begin
      n_fails++;
      $display("[TB] FAIL midop_reset: got sel=%b busy=%b addr=%h expected 0", sels(), bus.busy, bus.mem_addr);
    end
    bus.i_req = 1'b0;
    tick();
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({bus.i_ack, bus.d_ack} !== 2'b00) begin
        n_fails++;
        $display("[TB] FAIL midop_dropped: got iack=%b dack=%b expected 00", bus.i_ack, bus.d_ack);
      end
    end
    // Fresh tie straight out of reset must go to fetch first.
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h0000_0020;
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h0000_0030;
    bus.mem_rdata = 32'h1111_2222;
    tick();
    tick();
    n_checks++;
    if ({bus.i_ack, bus.d_ack, bus.i_rdata} !== {2'b10, 32'h1111_2222}) begin
      n_fails++;
      $display("[TB] FAIL tie_after_reset: got iack=%b dack=%b rdata=%h expected 1 0 11112222",
               bus.i_ack, bus.d_ack, bus.i_rdata);
    end
    tick();
    bus.i_req = 1'b0;
    bus.mem_rdata = 32'h3333_4444;
    tick();
    tick();
    n_checks++;
    if ({bus.i_ack, bus.d_ack, bus.d_err, bus.d_rdata} !== {3'b010, 32'h3333_4444}) begin
      n_fails++;
      $display("[TB] FAIL data_after_reset: got iack=%b dack=%b err=%b rdata=%h expected 0 1 0 33334444",
               bus.i_ack, bus.d_ack, bus.d_err, bus.d_rdata);
    end
    tick();
    bus.d_req = 1'b0;
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    bus.i_req     = 1'b0;
    bus.i_addr    = 32'd0;
    bus.d_req     = 1'b0;
    bus.d_addr    = 32'd0;
    bus.d_we      = 1'b0;
    bus.d_be      = 4'd0;
    bus.d_wdata   = 32'd0;
    bus.mem_rdata = 32'd0;
    test_reset();
    test_bram_read();
    test_wait_states();
    test_sram_write();
    test_error();
    test_round_robin();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
